deserializer_buffered: RTL and testbench
========================================

# deserializer_buffered

Parametrised, double-buffered serial-to-parallel converter for the serial link. Collects `WIDTH` bits from `data_in`, qualified by `write_in`, into a shift register and presents each completed word on `data_out` with a `data_ready`/`ack_in` handshake toward the downstream queue. A holding register decouples reception from consumption, so the next word can be received while the previous one awaits acknowledgement. Supports selectable bit order and flags dropped bits.

## Interface

Parameters:
- `WIDTH`, 8, word width in bits; legal range 2..32.
- `MSB_FIRST`, 0, 0: first received bit lands in `data_out[0]`; 1: first bit lands in `data_out[WIDTH-1]`.

Ports:
- `clock_100KHz`  in  1  sole clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-low reset; sampled on rising edge of `clock_100KHz`; dominates all other inputs.
- `data_in`  in  1  serial data bit.
- `write_in`  in  1  `data_in` is valid this cycle.
- `status_out`  out  1  1 = able to accept a bit this cycle.
- `data_out`  out  WIDTH  completed word (holding register).
- `data_ready`  out  1  `data_out` holds an unacknowledged word.
- `ack_in`  in  1  consumer takes `data_out`; meaningful only while `data_ready`=1.
- `overflow_out`  out  1  sticky: a bit was offered while `status_out`=0.

## Operation

- Reset (`reset`=0 at an edge): state RX, bit counter 0, shift register 0, `data_out`=0, `data_ready`=0, `status_out`=1, `overflow_out`=0. Applies mid-word or mid-stall; any partial or pending word is discarded.
- Bit counter: width `$clog2(WIDTH)`, range 0..WIDTH-1; returns to 0 after the last bit of a word. No other wrap.
- Bit accept: edge with `write_in`=1 and `status_out`=1. The bit is stored in the shift-register position for the counter's current value, and the counter increments. Bit position follows `MSB_FIRST`. Cycles with `write_in`=0 leave the counter and shift register unchanged, so gaps inside a word are allowed.
- States:
  - RX (`status_out`=1): accepting bits.
    - On the accept edge of the last bit (counter = WIDTH-1): if `data_ready`=0, or `ack_in`=1 at that same edge, load the full word into `data_out`, set `data_ready`=1, reset the counter to 0, and stay in RX.
    - Otherwise go to STALL with the full word held in the shift register.
  - STALL (`status_out`=0): holding register full and shift register full.
    - On an edge with `ack_in`=1: shift register → `data_out`, `data_ready` stays 1, counter 0, go to RX.
- Ack:
  - An edge with `ack_in`=1 and `data_ready`=1, and no new word loaded at that edge: `data_ready` → 0, and `data_out` keeps its last value.
  - `ack_in` while `data_ready`=0: ignored.
- Overflow: an edge with `write_in`=1 and `status_out`=0 drops the bit and sets `overflow_out`=1. The flag stays set until reset.
- `status_out` decodes only the state register; it has no combinational path from any input.

## Timing

- Latency: `data_out`/`data_ready` update at the same edge that accepts the last bit, and are visible in the following cycle. Minimum word period is WIDTH cycles.
- Sustained throughput: 1 bit/cycle with no stall, provided the consumer acks within WIDTH cycles of each `data_ready` rise.
- Simultaneous last-bit accept and `ack_in` in RX: the new word replaces the old one and `data_ready` remains 1 with no low cycle. The old word counts as consumed.
- STALL exit: `status_out` returns to 1 in the cycle after the ack edge. A `write_in` during the ack edge itself is dropped and counted as overflow.
- `reset` asserted at the same edge as any accept or ack: reset wins; outputs take reset values next cycle.

## Test plan

- Reset values: hold `reset`=0 for 2 cycles, then release → `status_out`=1, `data_ready`=0, `data_out`=0, `overflow_out`=0.
- Bit order: `WIDTH`=8. Send bits 1,0,1,0,0,0,0,0 on consecutive cycles.
  - `MSB_FIRST`=0 → `data_out`=8'h05.
  - `MSB_FIRST`=1 → `data_out`=8'hA0.
  - In both cases `data_ready`=1 one cycle after the 8th bit.
- Back-to-back with ack on the last-bit edge: stream 8'h3C then 8'hC3 continuously, asserting `ack_in` exactly at the edge of the 2nd word's last bit → `data_out` goes 8'h3C to 8'hC3, `data_ready` never drops, `status_out` stays 1.
- Stall and overflow: stream 8'h11 with no ack, then 8'h22 → `status_out`=0 after the 16th bit. A 17th `write_in` → `overflow_out`=1 and the bit is dropped. Then ack → `data_out`=8'h22, `data_ready`=1, `status_out`=1 the next cycle. Ack again → `data_ready`=0.
- Gaps and spurious ack: `WIDTH`=12, 12 bits with `write_in` low every other cycle and `ack_in` pulsed while `data_ready`=0 → word correct, no state change from the ack, and `data_ready` rises after the 12th accepted bit only.
- Reset mid-operation: 5 bits into a word while in STALL, drive `reset`=0 for 1 cycle → all reset values. The next 8 bits form a fresh word with no residue from before the reset.

Source files
------------

// File: rtl/deserializer_buffered.sv
`default_nettype none
// ============================================================================
// Module      : deserializer_buffered
// Description : Double-buffered serial-to-parallel converter. Bits qualified
//               by write_in are collected into a shift register. Each
//               completed word is moved to a holding register and offered
//               downstream with a data_ready/ack_in handshake, so the next
//               word can be received while the previous one waits.
// Ports       : clock_100KHz - sole clock, rising edge
//               reset        - synchronous, active-low
//               data_in      - serial data bit
//               write_in     - data_in valid this cycle
//               status_out   - 1 = a bit can be accepted this cycle
//               data_out     - completed word (holding register)
//               data_ready   - data_out holds an unacknowledged word
//               ack_in       - consumer takes data_out
//               overflow_out - sticky: a bit was offered while status_out=0
// Revision    : 1.0 - initial release
// ============================================================================
module deserializer_buffered #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clock_100KHz,
  input  logic             reset,
  input  logic             data_in,
  input  logic             write_in,
  output logic             status_out,
  output logic [WIDTH-1:0] data_out,
  output logic             data_ready,
  input  logic             ack_in,
  output logic             overflow_out
);

  localparam int            CW     = $clog2(WIDTH);
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    ST_RX    = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_data;
  logic             r_ready;
  logic             r_ovf;

  logic             w_accept;
  logic             w_last;
  logic             w_load;
  logic             w_unstall;
  logic             w_ack_clr;
  logic [CW-1:0]    w_idx;
  logic [WIDTH-1:0] w_word;

  always_comb begin
    w_accept  = write_in && (r_state == ST_RX);
    w_last    = w_accept && (r_cnt == C_LAST);
    // Last bit goes straight to the holding register when it is free or
    // being emptied at this same edge; otherwise the word parks in r_shift.
    w_load    = w_last && (!r_ready || ack_in);
    w_unstall = (r_state == ST_STALL) && ack_in;
    // A plain ack empties the holding register only when nothing refills it.
    w_ack_clr = ack_in && r_ready && !w_load && (r_state == ST_RX);
    w_idx     = MSB_FIRST ? (C_LAST - r_cnt) : r_cnt;
    // Shift register with the current bit merged in: this is the full word
    // on the last-bit edge.
    w_word        = r_shift;
    w_word[w_idx] = data_in;

    w_state_nxt = r_state;
    case (r_state)
      ST_RX:    if (w_last && !w_load) w_state_nxt = ST_STALL;
      ST_STALL: if (ack_in)            w_state_nxt = ST_RX;
      default:                         w_state_nxt = ST_RX;
    endcase
  end

  always_ff @(posedge clock_100KHz) begin
    if (!reset) begin
      r_state <= ST_RX;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clock_100KHz) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_ready <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_shift <= w_word;
        // Counter returns to 0 after the last bit whether the word was
        // loaded or parked; a parked word is released as a whole.
        r_cnt   <= (r_cnt == C_LAST) ? '0 : r_cnt + CW'(1);
      end

      if (w_load) begin
        r_data  <= w_word;
        r_ready <= 1'b1;
      end else if (w_unstall) begin
        r_data  <= r_shift;
        r_ready <= 1'b1;
      end else if (w_ack_clr) begin
        r_ready <= 1'b0;
      end

      if (write_in && (r_state == ST_STALL)) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign status_out   = (r_state == ST_RX);
  assign data_out     = r_data;
  assign data_ready   = r_ready;
  assign overflow_out = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_deserializer_buffered.sv
`default_nettype none
// ============================================================================
// Module      : tb_deserializer_buffered
// Description : Bench for deserializer_buffered. Three instances (8-bit LSB
//               first, 8-bit MSB first, 12-bit LSB first) share one stimulus
//               stream; a word-level model per instance predicts every
//               output on every cycle, and literal expectations pin the
//               directed scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_deserializer_buffered;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, din, wr, ack;
  logic st0, st1, st2, rdy0, rdy1, rdy2, ov0, ov1, ov2;
  logic [7:0]  d0, d1;
  logic [11:0] d2;

  deserializer_buffered #(.WIDTH(8), .MSB_FIRST(1'b0)) u0 (
    .clock_100KHz(clk), .reset(rst_n), .data_in(din), .write_in(wr),
    .status_out(st0), .data_out(d0), .data_ready(rdy0), .ack_in(ack),
    .overflow_out(ov0));
  deserializer_buffered #(.WIDTH(8), .MSB_FIRST(1'b1)) u1 (
    .clock_100KHz(clk), .reset(rst_n), .data_in(din), .write_in(wr),
    .status_out(st1), .data_out(d1), .data_ready(rdy1), .ack_in(ack),
    .overflow_out(ov1));
  deserializer_buffered #(.WIDTH(12), .MSB_FIRST(1'b0)) u2 (
    .clock_100KHz(clk), .reset(rst_n), .data_in(din), .write_in(wr),
    .status_out(st2), .data_out(d2), .data_ready(rdy2), .ack_in(ack),
    .overflow_out(ov2));

  int nvec  = 0;
  int nfail = 0;

  // Word-level model: partial word being collected, a parked full word
  // (present only while reception is blocked), and the offered word.
  int          mw[3];
  bit          mm[3];
  int          m_n[3];
  logic [31:0] m_part[3];
  logic [31:0] m_pword[3];
  logic [31:0] m_hold[3];
  bit          m_pend[3];
  bit          m_rdy[3];
  bit          m_ovf[3];

  task automatic model_step(int k);
    logic [31:0] w;
    int pos;
    bit loaded;
    if (!rst_n) begin
      m_n[k] = 0; m_part[k] = 0; m_pword[k] = 0; m_hold[k] = 0;
      m_pend[k] = 0; m_rdy[k] = 0; m_ovf[k] = 0;
      return;
    end
    if (m_pend[k]) begin
      if (wr) m_ovf[k] = 1;
      if (ack) begin
        m_hold[k] = m_pword[k];
        m_pend[k] = 0;
        m_rdy[k]  = 1;
      end
    end else begin
      loaded = 0;
      if (wr) begin
        pos = mm[k] ? (mw[k] - 1 - m_n[k]) : m_n[k];
        m_part[k][pos] = din;
        m_n[k]++;
        if (m_n[k] == mw[k]) begin
          w = m_part[k];
          m_part[k] = 0;
          m_n[k] = 0;
          if (!m_rdy[k] || ack) begin
            m_hold[k] = w;
            m_rdy[k]  = 1;
            loaded    = 1;
          end else begin
            m_pend[k]  = 1;
            m_pword[k] = w;
          end
        end
      end
      if (ack && m_rdy[k] && !loaded) m_rdy[k] = 0;
    end
  endtask

  function automatic logic [34:0] actual(int k);
    case (k)
      0:       return {st0, rdy0, ov0, 24'h0, d0};
      1:       return {st1, rdy1, ov1, 24'h0, d1};
      default: return {st2, rdy2, ov2, 20'h0, d2};
    endcase
  endfunction

  task automatic compare(int k);
    logic [34:0] e, a;
    e = {~m_pend[k], m_rdy[k], m_ovf[k], m_hold[k]};
    a = actual(k);
    nvec++;
    if (a !== e) begin
      nfail++;
      $display("FAIL model inst%0d t=%0t got st=%b rdy=%b ovf=%b data=%h want st=%b rdy=%b ovf=%b data=%h",
               k, $time, a[34], a[33], a[32], a[31:0], e[34], e[33], e[32], e[31:0]);
    end
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s t=%0t got %h want %h", name, $time, act, exp);
    end
  endtask

  // One clock: model advances on the edge, outputs checked 1 time unit later.
  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_step(k);
    #1;
    for (int k = 0; k < 3; k++) compare(k);
  endtask

  task automatic drive(bit w, bit d, bit a);
    wr = w; din = d; ack = a;
    tick();
    wr = 0; ack = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  task automatic send8(logic [7:0] v, bit ack_last, bit chk_hold);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, v[i], ack_last && (i == 7));
      if (chk_hold) begin
        check("b2b_ready", {31'h0, rdy0}, 32'h1);
        check("b2b_status", {31'h0, st0}, 32'h1);
      end
    end
  endtask

  initial begin
    logic [7:0]  pat;
    logic [11:0] w12;
    mw[0] = 8; mw[1] = 8; mw[2] = 12;
    mm[0] = 0; mm[1] = 1; mm[2] = 0;
    for (int k = 0; k < 3; k++) begin
      m_n[k] = 0; m_part[k] = 0; m_pword[k] = 0; m_hold[k] = 0;
      m_pend[k] = 0; m_rdy[k] = 0; m_ovf[k] = 0;
    end
    rst_n = 0; din = 0; wr = 0; ack = 0;

    // Reset values
    tick(); tick();
    rst_n = 1;
    check("rst_status", {31'h0, st0}, 32'h1);
    check("rst_ready", {31'h0, rdy0}, 32'h0);
    check("rst_data", {24'h0, d0}, 32'h0);
    check("rst_ovf", {31'h0, ov0}, 32'h0);

    // Bit order: 1,0,1,0,0,0,0,0
    pat = 8'b0000_0101;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, pat[i], 1'b0);
      if (i == 6) check("ord_early_ready", {31'h0, rdy0}, 32'h0);
    end
    check("ord_lsb", {24'h0, d0}, 32'h05);
    check("ord_msb", {24'h0, d1}, 32'hA0);
    check("ord_lsb_ready", {31'h0, rdy0}, 32'h1);
    check("ord_msb_ready", {31'h0, rdy1}, 32'h1);
    check("ord_model_msb", m_hold[1], 32'hA0);

    // Back-to-back with ack exactly on the second word's last bit
    do_reset();
    send8(8'h3C, 1'b0, 1'b0);
    check("b2b_first", {24'h0, d0}, 32'h3C);
    send8(8'hC3, 1'b1, 1'b1);
    check("b2b_second", {24'h0, d0}, 32'hC3);
    check("b2b_model", m_hold[0], 32'hC3);

    // Stall and overflow
    do_reset();
    send8(8'h11, 1'b0, 1'b0);
    send8(8'h22, 1'b0, 1'b0);
    check("stall_status", {31'h0, st0}, 32'h0);
    check("stall_ovf_pre", {31'h0, ov0}, 32'h0);
    drive(1'b1, 1'b1, 1'b0);
    check("stall_ovf", {31'h0, ov0}, 32'h1);
    check("stall_hold", {24'h0, d0}, 32'h11);
    drive(1'b0, 1'b0, 1'b1);
    check("unstall_data", {24'h0, d0}, 32'h22);
    check("unstall_ready", {31'h0, rdy0}, 32'h1);
    check("unstall_status", {31'h0, st0}, 32'h1);
    drive(1'b0, 1'b0, 1'b1);
    check("final_ack_ready", {31'h0, rdy0}, 32'h0);
    check("final_ack_data", {24'h0, d0}, 32'h22);

    // Gaps and spurious acks on the 12-bit instance
    do_reset();
    w12 = 12'hA5C;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, w12[i], 1'b0);
      check("gap_ready", {31'h0, rdy2}, (i == 11) ? 32'h1 : 32'h0);
      if (i < 11) begin
        drive(1'b0, 1'b0, 1'b1);
        check("gap_spur_ready", {31'h0, rdy2}, 32'h0);
        check("gap_spur_status", {31'h0, st2}, 32'h1);
      end
    end
    check("gap_word", {20'h0, d2}, 32'hA5C);

    // Reset while stalled with extra bits offered
    do_reset();
    for (int i = 0; i < 16; i++) drive(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    check("mid_stall", {31'h0, st0}, 32'h0);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0);
    do_reset();
    check("mid_rst_status", {31'h0, st0}, 32'h1);
    check("mid_rst_ready", {31'h0, rdy0}, 32'h0);
    check("mid_rst_data", {24'h0, d0}, 32'h0);
    check("mid_rst_ovf", {31'h0, ov0}, 32'h0);
    send8(8'h5A, 1'b0, 1'b0);
    check("fresh_word", {24'h0, d0}, 32'h5A);
    check("fresh_msb", {24'h0, d1}, 32'h5A);

    // Randomised traffic with varying ack rates and occasional reset
    for (int seg = 0; seg < 4; seg++) begin
      for (int c = 0; c < 1000; c++) begin
        rst_n = ($urandom_range(0, 299) != 0);
        wr    = ($urandom_range(0, 3) != 0);
        din   = 1'($urandom_range(0, 1));
        ack   = ($urandom_range(0, 2 + seg * 6) == 0);
        tick();
      end
    end
    rst_n = 1; wr = 0; ack = 0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
`default_nettype wire
